// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// dsp_pkg : shared DSP datapath defaults and pipeline latency
// Rev 1.0
// ============================================================================
package dsp_pkg;

    localparam int DSP_WIDTH = 32;
    localparam int DSP_FRAC  = 30;
    localparam int DSP_NREQ  = 4;
    localparam int MULT_LAT  = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// mult_arbiter_if : requester/response bundle for the shared multiplier
// Rev 1.0
// ============================================================================
interface mult_arbiter_if
    import dsp_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH,
    parameter int NREQ  = DSP_NREQ
);

    logic [NREQ-1:0]            req_valid_in;
    logic [NREQ-1:0][WIDTH-1:0] req_a_in;
    logic [NREQ-1:0][WIDTH-1:0] req_b_in;
    logic [NREQ-1:0]            req_mask_in;
    logic [NREQ-1:0]            req_ready_out;
    logic [NREQ-1:0]            resp_valid_out;
    logic [WIDTH-1:0]           resp_data_out;
    logic                       busy_out;

    modport master (
        output req_valid_in, req_a_in, req_b_in, req_mask_in,
        input  req_ready_out, resp_valid_out, resp_data_out, busy_out
    );

    modport slave (
        input  req_valid_in, req_a_in, req_b_in, req_mask_in,
        output req_ready_out, resp_valid_out, resp_data_out, busy_out
    );

endinterface
`default_nettype wire

// File: rtl/mult_pipe.sv
`default_nettype none
// ============================================================================
// mult_pipe : 3-stage signed fixed-point multiply, shift and saturate with tag
// Rev 1.0
// ============================================================================
module mult_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH,
    parameter int FRAC  = DSP_FRAC,
    parameter int TAG_W = idx_width(DSP_NREQ)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    i_valid,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic                    o_valid,
    output logic [TAG_W-1:0]        o_tag,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_busy
);

    localparam int c_PW = 2 * WIDTH;

    logic                    r_s1_valid, r_s2_valid, r_s3_valid;
    logic [TAG_W-1:0]        r_s1_tag, r_s2_tag, r_s3_tag;
    logic signed [WIDTH-1:0] r_s1_a, r_s1_b;
    logic signed [c_PW-1:0]  r_s2_prod;
    logic [WIDTH-1:0]        r_s3_data;

    logic signed [c_PW-1:0]  w_a_ext, w_b_ext, w_shift;
    logic [WIDTH-1:0]        w_sat;

    assign w_a_ext = c_PW'(r_s1_a);
    assign w_b_ext = c_PW'(r_s1_b);

    // Result fits only when the bits above the result sign all match it.
    always_comb begin
        w_shift = r_s2_prod >>> FRAC;
        w_sat   = w_shift[WIDTH-1:0];
        if (w_shift[c_PW-1:WIDTH-1] != {(WIDTH+1){w_shift[c_PW-1]}}) begin
            w_sat = w_shift[c_PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_s3_tag   <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_prod  <= '0;
            r_s3_data  <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s1_tag   <= i_tag;
            r_s2_tag   <= r_s1_tag;
            r_s3_tag   <= r_s2_tag;
            if (i_valid) begin
                r_s1_a <= i_a;
                r_s1_b <= i_b;
            end
            if (r_s1_valid) begin
                r_s2_prod <= w_a_ext * w_b_ext;
            end
            if (r_s2_valid) begin
                r_s3_data <= w_sat;
            end
        end
    end

    assign o_valid = r_s3_valid;
    assign o_tag   = r_s3_tag;
    assign o_data  = r_s3_data;
    assign o_busy  = r_s1_valid | r_s2_valid | r_s3_valid;

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// mult_arbiter : round-robin arbiter sharing one pipelined fixed-point multiplier
// Rev 1.0
// ============================================================================
module mult_arbiter
    import dsp_pkg::*;
#(
    parameter int WIDTH = DSP_WIDTH,
    parameter int FRAC  = DSP_FRAC,
    parameter int NREQ  = DSP_NREQ
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mult_arbiter_if.slave bus
);

    localparam int c_IDX_W = idx_width(NREQ);

    logic [c_IDX_W-1:0] r_ptr;
    logic [NREQ-1:0]    w_elig;
    logic [NREQ-1:0]    w_grant;
    logic [c_IDX_W-1:0] w_gnt_idx;
    logic               w_xfer;
    logic               w_pipe_valid;
    logic [c_IDX_W-1:0] w_pipe_tag;
    logic [WIDTH-1:0]   w_pipe_data;
    logic               w_pipe_busy;

    assign w_elig = bus.req_valid_in & bus.req_mask_in;

    // Scanning from the far end lets the candidate nearest ptr+1 win last.
    always_comb begin : p_arb
        int idx;
        idx       = 0;
        w_grant   = '0;
        w_gnt_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(r_ptr) + i) % NREQ;
            if (w_elig[c_IDX_W'(idx)]) begin
                w_grant   = NREQ'(1) << idx;
                w_gnt_idx = c_IDX_W'(idx);
            end
        end
        if (!rst_in) begin
            w_grant = '0;
        end
    end

    assign w_xfer            = |w_grant;
    assign bus.req_ready_out = w_grant;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_ptr <= c_IDX_W'(NREQ - 1);
        end else if (w_xfer) begin
            r_ptr <= w_gnt_idx;
        end
    end

    mult_pipe #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .TAG_W (c_IDX_W)
    ) u_pipe (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_valid (w_xfer),
        .i_tag   (w_gnt_idx),
        .i_a     (bus.req_a_in[w_gnt_idx]),
        .i_b     (bus.req_b_in[w_gnt_idx]),
        .o_valid (w_pipe_valid),
        .o_tag   (w_pipe_tag),
        .o_data  (w_pipe_data),
        .o_busy  (w_pipe_busy)
    );

    assign bus.resp_valid_out = w_pipe_valid ? (NREQ'(1) << w_pipe_tag) : '0;
    assign bus.resp_data_out  = w_pipe_data;
    assign bus.busy_out       = w_pipe_busy;

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand/result width; FRAC, default 30, fractional bits of signed fixed-point operands; NREQ, default 4, number of requesters.
REQ-002 clk_in  input  1  the only clock; all state SHALL change on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_in  input  NREQ  per-requester request valid.
REQ-005 req_a_in  input  NREQ x WIDTH  signed multiplicand per requester.
REQ-006 req_b_in  input  NREQ x WIDTH  signed multiplier per requester.
REQ-007 req_mask_in  input  NREQ  1 = requester enabled; masked requesters are never granted.
REQ-008 req_ready_out  output  NREQ  one-hot grant; a transfer occurs on an edge where valid and ready are both 1.
REQ-009 resp_valid_out  output  NREQ  one-hot, single-cycle result strobe identifying the owner.
REQ-010 resp_data_out  output  WIDTH  signed fixed-point product; valid only while resp_valid_out is non-zero.
REQ-011 busy_out  output  1  1 while any operation is in flight.

Function
REQ-012 req_ready_out SHALL be combinational from req_valid_in, req_mask_in and the priority pointer, with at most one bit set.
REQ-013 A bit of req_ready_out SHALL be 1 only if the matching requester is valid and enabled.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer+1 mod NREQ and the first valid enabled requester is granted.
REQ-015 On a transfer the pointer SHALL take the index of the granted requester; otherwise the pointer SHALL hold.
REQ-016 Requesters SHALL hold valid and operands stable until ready; the arbiter imposes no ordering beyond REQ-014.
REQ-017 The pipeline SHALL be fully pipelined, with 3 stages: operand register, product register, result register.
REQ-018 A transfer SHALL be accepted every cycle when requests are pending; sustained throughput is 1 operation per clock.
REQ-019 An operation accepted at rising edge k SHALL drive resp_valid_out and resp_data_out after edge k+2, for exactly one cycle.
REQ-020 The owner index SHALL travel down the pipeline with the operands; responses SHALL return in acceptance order.
REQ-021 Responses SHALL have no backpressure; requesters SHALL always sink them.
REQ-022 The product SHALL be the full 2*WIDTH signed product, arithmetically shifted right by FRAC (floor rounding).
REQ-023 The shifted product SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 busy_out SHALL be the OR of the three stage-valid bits.
REQ-025 Deasserting a req_mask_in bit SHALL block new grants to that requester and SHALL NOT cancel its in-flight operations.
REQ-026 When all requests are invalid or masked, req_ready_out SHALL be 0 and the pipeline SHALL drain normally.

Reset
REQ-027 While rst_in=0, the following SHALL hold: all stage-valid bits 0, resp_valid_out 0, resp_data_out 0, busy_out 0, pointer NREQ-1 (requester 0 highest priority).
REQ-028 Reset asserted mid-operation SHALL discard in-flight operations; no resp_valid_out pulse SHALL occur for them after release.
REQ-029 req_ready_out SHALL be 0 during reset regardless of req_valid_in.

Structure
REQ-030 The shared package dsp_pkg SHALL hold the default WIDTH, FRAC and NREQ, and the pipeline latency constant MULT_LAT=2.
REQ-031 The multiply, shift and saturate datapath SHALL be the sub-module mult_pipe.
REQ-032 mult_pipe SHALL carry an opaque tag (the owner index) and a valid bit through its stages.
REQ-033 The arbiter and pointer logic SHALL reside in mult_arbiter.

Verification
REQ-034 The bench SHALL cover: requester 0 sends a=0x1000_0000, b=0x4000_0000 (0.25x1.0) at edge 10 -> resp_valid_out=0001 after edge 12, resp_data_out=0x1000_0000.
REQ-035 The bench SHALL cover: all 4 requesters valid continuously from reset -> grants in order 0,1,2,3,0,... with one transfer per cycle and responses in the same order 2 cycles later.
REQ-036 The bench SHALL cover saturation: a=b=0x6000_0000 (1.5x1.5) -> 0x7FFF_FFFF; a=0x4000_0000, b=0x8000_0000 (1.0x-2.0) -> 0x8000_0000.
REQ-037 The bench SHALL cover floor rounding: a=0xFFFF_FFFF, b=0x0000_0001 -> 0xFFFF_FFFF.
REQ-038 The bench SHALL cover masking: requesters 1 and 3 valid, mask=1101 -> only requester 3 is granted; after the mask changes to 1111, the next grant after 3 goes to 1.
REQ-039 The bench SHALL cover reset: rst_in pulsed low one cycle after two transfers -> no resp_valid_out pulse, busy_out=0, and the next grant starts from requester 0.
